// File: rtl/multihex_display.sv
// multihex_display: N-digit multiplexed hex driver for common-anode 7-segment
// displays. Digits are scanned one at a time. Each digit goes through
// IDLE -> SETUP -> SHOW (HOLD_CYCLES) -> GAP, so it takes HOLD_CYCLES+3 cycles.
// Segments only change on entry to SETUP, while every select is off, so the
// display never ghosts. dataword/dp/blank are snapshotted in the digit-0 IDLE,
// which means a frame always shows one consistent value.
//
// Parameters:
//   NUM_DIGITS  (1..16)  digits scanned
//   HOLD_CYCLES (>=1)    cycles each digit stays selected
// Ports:
//   clk_i          clock
//   rst_ni         async active-low reset
//   enable_i       1 = scan, 0 = park in IDLE with all digits off
//   dataword_i     nibble k (bits 4k+3:4k) is shown on digit k
//   dp_i           active-high decimal point per digit
//   blank_i        active-high per-digit blank (segments and DP off)
//   sel_o          active-low digit select, bit k = digit k
//   seg_o          active-low segments, [0]=a .. [6]=g, [7]=DP
//   frame_done_o   one-cycle pulse in the GAP of the last digit
// Optional feature (macro LEADING_ZERO_BLANK_EN): blank digit k>0 when every
// shadow nibble from k upward is zero, unless that digit's DP is set.
module multihex_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int HOLD_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [4*NUM_DIGITS-1:0]   dataword_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  input  logic [NUM_DIGITS-1:0]     blank_i,
  output logic [NUM_DIGITS-1:0]     sel_o,
  output logic [7:0]                seg_o,
  output logic                      frame_done_o
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHOW, GAP} state_e;

  state_e                    state_q, state_d;
  logic [DW-1:0]             digit_q, digit_d;
  logic [HW-1:0]             hold_q, hold_d;
  logic [4*NUM_DIGITS-1:0]   sh_dw_q, sh_dw_d;
  logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]     sh_bl_q, sh_bl_d;
  logic [NUM_DIGITS-1:0]     sel_q, sel_d;
  logic [7:0]                seg_q, seg_d;
  logic                      fd_q, fd_d;

  // Outputs are registered from next-state values, so they line up with the
  // state the FSM is in during that cycle.
  assign sel_o        = sel_q;
  assign seg_o        = seg_q;
  assign frame_done_o = fd_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // In the digit-0 IDLE the glyph is decoded straight from the inputs being
  // snapshotted, so the first digit of a frame already uses the new data.
  logic                      snap;
  logic [4*NUM_DIGITS-1:0]   src_dw, nib_sh;
  logic [NUM_DIGITS-1:0]     src_dp, src_bl, dp_sh, bl_sh, sel_on;
  logic [7:0]                glyph;

  assign snap   = (state_q == IDLE) && (digit_q == '0);
  assign src_dw = snap ? dataword_i : sh_dw_q;
  assign src_dp = snap ? dp_i       : sh_dp_q;
  assign src_bl = snap ? blank_i    : sh_bl_q;
  assign sel_on = ~(NUM_DIGITS'(1) << digit_q);

  always_comb begin
    // nib_sh holds the current nibble and everything above it
    nib_sh = src_dw >> {digit_q, 2'b00};
    dp_sh  = src_dp >> digit_q;
    bl_sh  = src_bl >> digit_q;
    glyph  = {~dp_sh[0], hex7(nib_sh[3:0])};
`ifdef LEADING_ZERO_BLANK_EN
    if ((digit_q != '0) && !dp_sh[0] && (nib_sh == '0)) glyph = 8'hFF;
`endif
    if (bl_sh[0]) glyph = 8'hFF;
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    hold_d  = hold_q;
    sh_dw_d = sh_dw_q;
    sh_dp_d = sh_dp_q;
    sh_bl_d = sh_bl_q;
    sel_d   = '1;
    seg_d   = seg_q;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          sh_dw_d = src_dw;
          sh_dp_d = src_dp;
          sh_bl_d = src_bl;
          seg_d   = glyph;
          state_d = SETUP;
        end
      end
      SETUP: begin
        hold_d  = '0;
        sel_d   = sel_on;
        state_d = SHOW;
      end
      SHOW: begin
        hold_d = HW'(hold_q + 1'b1);
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = GAP;
          fd_d    = (digit_q == DW'(NUM_DIGITS - 1));
        end else begin
          sel_d = sel_on;
        end
      end
      default: begin // GAP
        digit_d = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : DW'(digit_q + 1'b1);
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      digit_q <= '0;
      hold_q  <= '0;
      sh_dw_q <= '0;
      sh_dp_q <= '0;
      sh_bl_q <= '0;
      sel_q   <= '1;
      seg_q   <= 8'hFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      hold_q  <= hold_d;
      sh_dw_q <= sh_dw_d;
      sh_dp_q <= sh_dp_d;
      sh_bl_q <= sh_bl_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

endmodule
